// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
// No logic: requester IDs and access-size encodings only.
// No flow control of its own.
package rv_mem_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_id_fifo.sv
// Small generic FIFO holding the requester ID of each read in flight.
// Latency: head valid the cycle after push; no bypass from push to head.
// Backpressure: caller must not push when full nor pop when empty; push+pop together is legal.
module mem_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage write; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking, pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data; routes in-order read responses by ID.
// Latency: request and response paths are combinational (0 cycles); lock/starve/ID state is registered.
// Backpressure: mem_req_ready passes to the granted requester; reads stall while the ID FIFO is full.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic        data_req_wr,
    input  logic [31:0] data_req_addr,
    input  logic [1:0]  data_req_size,
    input  logic [31:0] data_req_data,
    output logic        data_rsp_valid,
    output logic [31:0] data_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wr,
    output logic [31:0] mem_req_addr,
    output logic [1:0]  mem_req_size,
    output logic [31:0] mem_req_data,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_orphan
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          lock_vld;
    req_id_e       lock_id;
    req_id_e       sel_id;
    logic          sel_valid;
    logic          sel_wr;
    logic          can_issue;
    logic          handshake;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [0:0]    fifo_head;
    req_id_e       head_id;
    logic [SW-1:0] starve_cnt;

    // Requester selection: a pending lock wins, then starvation relief, then data priority.
    always_comb begin
        sel_id = REQ_DATA;
        if (lock_vld) begin
            sel_id = lock_id;
        end else if (instr_req_valid && (starve_cnt == SW'(STARVE_LIMIT))) begin
            sel_id = REQ_INSTR;
        end else if (!data_req_valid && instr_req_valid) begin
            sel_id = REQ_INSTR;
        end
    end

    assign sel_valid = (sel_id == REQ_INSTR) ? instr_req_valid : data_req_valid;
    assign sel_wr    = (sel_id == REQ_DATA) && data_req_wr;
    // Full blocks reads even when a pop lands in the same cycle; writes never need a slot.
    assign can_issue = sel_wr || !fifo_full;

    assign mem_req_valid = !reset && sel_valid && can_issue;
    assign mem_req_wr    = sel_wr;
    assign mem_req_addr  = (sel_id == REQ_INSTR) ? instr_req_addr : data_req_addr;
    assign mem_req_size  = (sel_id == REQ_INSTR) ? SIZE_WORD : data_req_size;
    assign mem_req_data  = (sel_id == REQ_INSTR) ? 32'h0 : data_req_data;

    assign instr_req_ready = !reset && (sel_id == REQ_INSTR) && mem_req_ready && can_issue;
    assign data_req_ready  = !reset && (sel_id == REQ_DATA) && mem_req_ready && can_issue;

    assign handshake = mem_req_valid && mem_req_ready;
    assign fifo_push = handshake && !sel_wr;
    assign fifo_pop  = !reset && mem_rsp_valid && !fifo_empty;
    assign head_id   = req_id_e'(fifo_head);

    assign instr_rsp_valid = fifo_pop && (head_id == REQ_INSTR);
    assign data_rsp_valid  = fifo_pop && (head_id == REQ_DATA);
    assign instr_rsp_data  = mem_rsp_data;
    assign data_rsp_data   = mem_rsp_data;

    mem_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (1'(sel_id)),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Hold the granted requester while the downstream stalls so the payload stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld <= 1'b0;
            lock_id  <= REQ_DATA;
        end else begin
            lock_vld <= mem_req_valid && !mem_req_ready;
            lock_id  <= sel_id;
        end
    end

    // Count data grants taken while fetch waits; saturates so fetch is forced next.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!instr_req_valid || (handshake && sel_id == REQ_INSTR)) begin
            starve_cnt <= '0;
        end else if (handshake && sel_id == REQ_DATA && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Sticky flag for a read response arriving with no outstanding ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_orphan <= 1'b0;
        end else if (mem_rsp_valid && fifo_empty) begin
            rsp_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one table of per-cycle vectors plus hand sequences.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
// No flow control of its own; every step is a fixed number of cycles.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req_valid, instr_req_ready;
    logic [31:0] instr_req_addr;
    logic        instr_rsp_valid;
    logic [31:0] instr_rsp_data;
    logic        data_req_valid, data_req_ready, data_req_wr;
    logic [31:0] data_req_addr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_wr;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_data;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rsp_orphan;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] IADDR = 32'h0000_1000;
    localparam logic [31:0] DDATA = 32'h5A5A_1234;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req_valid (instr_req_valid),
        .instr_req_ready (instr_req_ready),
        .instr_req_addr  (instr_req_addr),
        .instr_rsp_valid (instr_rsp_valid),
        .instr_rsp_data  (instr_rsp_data),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_req_wr     (data_req_wr),
        .data_req_addr   (data_req_addr),
        .data_req_size   (data_req_size),
        .data_req_data   (data_req_data),
        .data_rsp_valid  (data_rsp_valid),
        .data_rsp_data   (data_rsp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_wr      (mem_req_wr),
        .mem_req_addr    (mem_req_addr),
        .mem_req_size    (mem_req_size),
        .mem_req_data    (mem_req_data),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .rsp_orphan      (rsp_orphan)
    );

    typedef struct packed {
        logic        iv;
        logic        dv;
        logic        dwr;
        logic [31:0] daddr;
        logic        rdy;
        logic        rv;
        logic [31:0] rdat;
        logic        e_mv;
        logic [31:0] e_addr;
        logic        e_wr;
        logic        e_ir;
        logic        e_dr;
        logic        e_irv;
        logic        e_drv;
        logic        e_orph;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic iv, dv, dwr, input logic [31:0] daddr,
                                input logic rdy, rv, input logic [31:0] rdat,
                                input logic e_mv, input logic [31:0] e_addr,
                                input logic e_wr, e_ir, e_dr, e_irv, e_drv, e_orph);
        vec_t v;
        v.iv = iv; v.dv = dv; v.dwr = dwr; v.daddr = daddr;
        v.rdy = rdy; v.rv = rv; v.rdat = rdat;
        v.e_mv = e_mv; v.e_addr = e_addr; v.e_wr = e_wr;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_irv = e_irv; v.e_drv = e_drv; v.e_orph = e_orph;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, dv, dwr, input logic [31:0] daddr, input logic [1:0] dsize,
                         input logic rdy, rv, input logic [31:0] rdat);
        instr_req_valid = iv;
        instr_req_addr  = IADDR;
        data_req_valid  = dv;
        data_req_wr     = dwr;
        data_req_addr   = daddr;
        data_req_size   = dsize;
        data_req_data   = DDATA;
        mem_req_ready   = rdy;
        mem_rsp_valid   = rv;
        mem_rsp_data    = rdat;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, " instr_req_ready"}, 32'(instr_req_ready), 32'd0);
        chk({tag, " data_req_ready"}, 32'(data_req_ready), 32'd0);
        chk({tag, " instr_rsp_valid"}, 32'(instr_rsp_valid), 32'd0);
        chk({tag, " data_rsp_valid"}, 32'(data_rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Starvation pattern (stores vs fetches), response routing, lock, full FIFO, orphan.
        tbl[0]  = mk(1,1,1,32'h2000,1,0,32'h0,          1,32'h2000,1,0,1,0,0,0);
        tbl[1]  = mk(1,1,1,32'h2000,1,0,32'h0,          1,32'h2000,1,0,1,0,0,0);
        tbl[2]  = mk(1,1,1,32'h2000,1,0,32'h0,          1,32'h2000,1,0,1,0,0,0);
        tbl[3]  = mk(1,1,1,32'h2000,1,0,32'h0,          1,32'h2000,1,0,1,0,0,0);
        tbl[4]  = mk(1,1,1,32'h2000,1,0,32'h0,          1,IADDR,   0,1,0,0,0,0);
        tbl[5]  = mk(1,1,1,32'h2000,1,0,32'h0,          1,32'h2000,1,0,1,0,0,0);
        tbl[6]  = mk(0,0,0,32'h0,   0,1,32'hAAAA_0001,  0,32'h0,   0,0,0,1,0,0);
        tbl[7]  = mk(1,1,0,32'h0100,0,0,32'h0,          1,32'h0100,0,0,0,0,0,0);
        tbl[8]  = mk(1,1,0,32'h0100,0,0,32'h0,          1,32'h0100,0,0,0,0,0,0);
        tbl[9]  = mk(1,1,0,32'h0100,0,0,32'h0,          1,32'h0100,0,0,0,0,0,0);
        tbl[10] = mk(1,1,0,32'h0100,1,0,32'h0,          1,32'h0100,0,0,1,0,0,0);
        tbl[11] = mk(1,0,0,32'h0,   0,0,32'h0,          1,IADDR,   0,0,0,0,0,0);
        tbl[12] = mk(1,1,0,32'h0300,0,0,32'h0,          1,IADDR,   0,0,0,0,0,0);
        tbl[13] = mk(1,1,0,32'h0300,1,0,32'h0,          1,IADDR,   0,1,0,0,0,0);
        tbl[14] = mk(0,1,0,32'h0300,1,1,32'hBBBB_0002,  0,32'h0,   0,0,0,0,1,0);
        tbl[15] = mk(0,1,0,32'h0300,1,1,32'hAAAA_0001,  1,32'h0300,0,0,1,1,0,0);
        tbl[16] = mk(0,0,0,32'h0,   0,1,32'hCCCC_0003,  0,32'h0,   0,0,0,0,1,0);
        tbl[17] = mk(0,0,0,32'h0,   0,1,32'hDDDD_0004,  0,32'h0,   0,0,0,0,0,0);
        tbl[18] = mk(0,0,0,32'h0,   0,0,32'h0,          0,32'h0,   0,0,0,0,0,1);
        tbl[19] = mk(1,0,0,32'h0,   0,0,32'h0,          1,IADDR,   0,0,0,0,0,1);

        // Reset held with all inputs active: outputs must stay quiet.
        reset = 1'b1;
        drive(1,1,0,32'h40,2'd2,1,1,32'h1);
        tick();
        chk_quiet("reset_active");
        tick();
        reset = 1'b0;
        drive(0,0,0,32'h0,2'd2,0,0,32'h0);
        chk("reset_orphan", 32'(rsp_orphan), 32'd0);
        chk_quiet("reset_idle");

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].iv, tbl[i].dv, tbl[i].dwr, tbl[i].daddr, 2'd2,
                  tbl[i].rdy, tbl[i].rv, tbl[i].rdat);
            chk($sformatf("row%0d mem_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("row%0d mem_req_addr", i), mem_req_addr, tbl[i].e_addr);
                chk($sformatf("row%0d mem_req_wr", i), 32'(mem_req_wr), 32'(tbl[i].e_wr));
                chk($sformatf("row%0d mem_req_size", i), 32'(mem_req_size), 32'd2);
                chk($sformatf("row%0d mem_req_data", i), mem_req_data,
                    (tbl[i].e_addr == IADDR) ? 32'h0 : DDATA);
            end
            chk($sformatf("row%0d instr_req_ready", i), 32'(instr_req_ready), 32'(tbl[i].e_ir));
            chk($sformatf("row%0d data_req_ready", i), 32'(data_req_ready), 32'(tbl[i].e_dr));
            chk($sformatf("row%0d instr_rsp_valid", i), 32'(instr_rsp_valid), 32'(tbl[i].e_irv));
            chk($sformatf("row%0d data_rsp_valid", i), 32'(data_rsp_valid), 32'(tbl[i].e_drv));
            if (tbl[i].e_irv) chk($sformatf("row%0d instr_rsp_data", i), instr_rsp_data, tbl[i].rdat);
            if (tbl[i].e_drv) chk($sformatf("row%0d data_rsp_data", i), data_rsp_data, tbl[i].rdat);
            chk($sformatf("row%0d rsp_orphan", i), 32'(rsp_orphan), 32'(tbl[i].e_orph));
            tick();
        end

        // Two reads fill the ID FIFO; a third read stalls but a byte store still issues.
        reset = 1'b1;
        drive(0,0,0,32'h0,2'd2,0,0,32'h0);
        tick();
        reset = 1'b0;
        chk("fullA orphan_cleared", 32'(rsp_orphan), 32'd0);
        drive(0,1,0,32'h10,2'd2,1,0,32'h0);
        chk("fullA rd1 ready", 32'(data_req_ready), 32'd1);
        tick();
        drive(0,1,0,32'h14,2'd2,1,0,32'h0);
        chk("fullA rd2 ready", 32'(data_req_ready), 32'd1);
        tick();
        drive(0,1,0,32'h18,2'd2,1,0,32'h0);
        chk("fullA rd3 valid", 32'(mem_req_valid), 32'd0);
        chk("fullA rd3 ready", 32'(data_req_ready), 32'd0);
        tick();
        drive(0,1,1,32'h200,2'd0,1,0,32'h0);
        chk("fullA st valid", 32'(mem_req_valid), 32'd1);
        chk("fullA st wr", 32'(mem_req_wr), 32'd1);
        chk("fullA st addr", mem_req_addr, 32'h200);
        chk("fullA st size", 32'(mem_req_size), 32'd0);
        chk("fullA st data", mem_req_data, DDATA);
        chk("fullA st ready", 32'(data_req_ready), 32'd1);
        tick();
        drive(0,0,0,32'h0,2'd2,0,1,32'h1111_0001);
        chk("fullA rsp1 data_valid", 32'(data_rsp_valid), 32'd1);
        tick();
        drive(0,0,0,32'h0,2'd2,0,1,32'h1111_0002);
        chk("fullA rsp2 data_valid", 32'(data_rsp_valid), 32'd1);
        chk("fullA rsp2 orphan", 32'(rsp_orphan), 32'd0);
        tick();
        drive(0,0,0,32'h0,2'd2,0,1,32'h1111_0003);
        chk("fullA rsp3 data_valid", 32'(data_rsp_valid), 32'd0);
        chk("fullA rsp3 instr_valid", 32'(instr_rsp_valid), 32'd0);
        tick();
        drive(0,0,0,32'h0,2'd2,0,0,32'h0);
        chk("fullA rsp3 orphan", 32'(rsp_orphan), 32'd1);

        // Reset with a fetch then a load outstanding discards the stale IDs.
        drive(1,0,0,32'h0,2'd2,1,0,32'h0);
        chk("rstB fetch ready", 32'(instr_req_ready), 32'd1);
        tick();
        drive(0,1,0,32'h50,2'd2,1,0,32'h0);
        chk("rstB load ready", 32'(data_req_ready), 32'd1);
        tick();
        reset = 1'b1;
        drive(1,1,0,32'h60,2'd2,1,0,32'h0);
        chk("rstB in_reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        reset = 1'b0;
        drive(0,0,0,32'h0,2'd2,0,0,32'h0);
        chk_quiet("rstB after");
        chk("rstB after orphan", 32'(rsp_orphan), 32'd0);
        drive(0,1,0,32'h40,2'd2,1,0,32'h0);
        chk("rstB fresh valid", 32'(mem_req_valid), 32'd1);
        chk("rstB fresh addr", mem_req_addr, 32'h40);
        chk("rstB fresh ready", 32'(data_req_ready), 32'd1);
        tick();
        drive(0,0,0,32'h0,2'd2,0,1,32'h1234_5678);
        chk("rstB rsp data_valid", 32'(data_rsp_valid), 32'd1);
        chk("rstB rsp instr_valid", 32'(instr_rsp_valid), 32'd0);
        chk("rstB rsp data", data_rsp_data, 32'h1234_5678);
        tick();
        drive(0,0,0,32'h0,2'd2,0,1,32'h9999_0000);
        chk("rstB extra data_valid", 32'(data_rsp_valid), 32'd0);
        chk("rstB extra instr_valid", 32'(instr_rsp_valid), 32'd0);
        tick();
        drive(0,0,0,32'h0,2'd2,0,0,32'h0);
        chk("rstB extra orphan", 32'(rsp_orphan), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
